// File: rtl/avmm_burst_slave_mem_if.sv
// Avalon-MM slave-side bus bundle for the burst slave memory.
// The master modport is the view a driving master (or bench) takes.
interface avmm_burst_slave_mem_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int BURST_W = 5
);
  logic [ADDR_W-1:0]     avs_address;
  logic                  avs_read;
  logic                  avs_write;
  logic [DATA_W-1:0]     avs_writedata;
  logic [DATA_W/8-1:0]   avs_byteenable;
  logic [BURST_W-1:0]    avs_burstcount;
  logic                  avs_waitrequest;
  logic [DATA_W-1:0]     avs_readdata;
  logic                  avs_readdatavalid;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
           avs_byteenable, avs_burstcount,
    output avs_waitrequest, avs_readdata, avs_readdatavalid
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
           avs_byteenable, avs_burstcount,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/avmm_burst_slave_mem.sv
// Avalon-MM burst slave backed by an on-chip word RAM.
// One command at a time; read beats come back two cycles after acceptance
// and stream back to back. Illegal commands are dropped and counted.
module avmm_burst_slave_mem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int BURST_W = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  avmm_burst_slave_mem_if.slave   avs,
  output logic                    protocol_err,
  output logic [7:0]              err_count
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [BURST_W-1:0] MAX_BURST = BURST_W'(2 ** (BURST_W - 1));

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_ISSUE = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_waitrequest;
  logic [ADDR_W-1:0]   r_addr;
  logic [BURST_W-1:0]  r_beatsLeft;
  logic                r_rdValid;
  logic [DATA_W-1:0]   r_rdData;
  logic                r_protoErr;
  logic [7:0]          r_errCount;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic                w_badCount;
  logic                w_idleIllegal;
  logic                w_burstIllegal;
  logic                w_illegal;
  logic                w_wrEn;
  logic [ADDR_W-1:0]   w_wrAddr;

  // Decode command legality and the RAM write strobe for the current cycle.
  // The first IDLE cycle after reset still shows waitrequest, so nothing is
  // taken until the registered waitrequest has dropped.
  always_comb begin
    w_accept       = ~r_waitrequest;
    w_badCount     = (avs.avs_burstcount == '0) || (avs.avs_burstcount > MAX_BURST);
    w_idleIllegal  = (r_state == IDLE) && w_accept && (avs.avs_read || avs.avs_write) &&
                     ((avs.avs_read && avs.avs_write) || w_badCount);
    w_burstIllegal = (r_state == WR_BURST) && avs.avs_read;
    w_illegal      = w_idleIllegal || w_burstIllegal;
    w_wrEn         = w_accept && avs.avs_write && !w_illegal &&
                     ((r_state == IDLE) || (r_state == WR_BURST));
    w_wrAddr       = (r_state == IDLE) ? avs.avs_address : r_addr;
  end

  // Command FSM with registered waitrequest, readdatavalid and error outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_waitrequest <= 1'b1;
      r_addr        <= '0;
      r_beatsLeft   <= '0;
      r_rdValid     <= 1'b0;
      r_protoErr    <= 1'b0;
      r_errCount    <= 8'd0;
    end else begin
      r_protoErr <= w_illegal;
      if (w_illegal && (r_errCount != 8'hFF)) begin
        r_errCount <= r_errCount + 8'd1;
      end
      r_rdValid <= (r_state == RD_ISSUE);
      case (r_state)
        IDLE: begin
          r_waitrequest <= 1'b0;
          if (w_accept && !w_illegal) begin
            if (avs.avs_write) begin
              if (avs.avs_burstcount != BURST_W'(1)) begin
                r_state     <= WR_BURST;
                r_beatsLeft <= avs.avs_burstcount - BURST_W'(1);
                r_addr      <= avs.avs_address + ADDR_W'(1);
              end
            end else if (avs.avs_read) begin
              r_state       <= RD_ISSUE;
              r_waitrequest <= 1'b1;
              r_beatsLeft   <= avs.avs_burstcount;
              r_addr        <= avs.avs_address;
            end
          end
        end
        WR_BURST: begin
          if (w_wrEn) begin
            r_addr      <= r_addr + ADDR_W'(1);
            r_beatsLeft <= r_beatsLeft - BURST_W'(1);
            if (r_beatsLeft == BURST_W'(1)) begin
              r_state <= IDLE;
            end
          end
        end
        RD_ISSUE: begin
          r_addr      <= r_addr + ADDR_W'(1);
          r_beatsLeft <= r_beatsLeft - BURST_W'(1);
          if (r_beatsLeft == BURST_W'(1)) begin
            r_state <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          r_state       <= IDLE;
          r_waitrequest <= 1'b0;
        end
        default: begin
          r_state       <= IDLE;
          r_waitrequest <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane masked RAM write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      for (int i = 0; i < BE_W; i++) begin
        if (avs.avs_byteenable[i]) begin
          r_mem[w_wrAddr][i*8 +: 8] <= avs.avs_writedata[i*8 +: 8];
        end
      end
    end
  end

  // Registered RAM read port, one issue per RD_ISSUE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdData <= '0;
    end else if (r_state == RD_ISSUE) begin
      r_rdData <= r_mem[r_addr];
    end
  end

  assign avs.avs_waitrequest   = r_waitrequest;
  assign avs.avs_readdatavalid = r_rdValid;
  assign avs.avs_readdata      = r_rdData;
  assign protocol_err          = r_protoErr;
  assign err_count             = r_errCount;

endmodule

// File: tb/tb_avmm_burst_slave_mem.sv
// Self-checking bench for avmm_burst_slave_mem: reset, a vector table of
// single-beat commands, hand-written burst/wrap/abort sequences and random
// bursts checked against a plain array model of the memory.
module tb_avmm_burst_slave_mem;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 8;
  localparam int BURST_W = 5;
  localparam int DEPTH   = 256;

  typedef enum int {VEC_WR, VEC_RD, VEC_ILL} vecKind_t;
  typedef struct {
    vecKind_t    kind;
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [4:0]  bc;
    logic [31:0] expData;
    logic [7:0]  expErr;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetN;
  logic        protocolErr;
  logic [7:0]  errCount;
  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] mdlMem [DEPTH];
  logic [31:0] wrBuf [16];
  logic [31:0] expBuf [16];
  vec_t        vecs [9];

  avmm_burst_slave_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) avs ();

  avmm_burst_slave_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) dut (
    .clk          (clk),
    .reset_n      (resetN),
    .avs          (avs),
    .protocol_err (protocolErr),
    .err_count    (errCount)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic waitReady();
    int cnt = 0;
    while (avs.avs_waitrequest !== 1'b0 && cnt < 64) begin
      tick();
      cnt++;
    end
    checkOutput("ready before command", 32'(avs.avs_waitrequest), 32'd0);
  endtask

  task automatic mergeModel(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mdlMem[addr][i*8 +: 8] = data[i*8 +: 8];
    end
  endtask

  task automatic loadExpFromModel(input logic [7:0] addr, input int n);
    for (int k = 0; k < n; k++) expBuf[k] = mdlMem[addr + 8'(k)];
  endtask

  task automatic writeBurst(input logic [7:0] addr, input int n, input logic [3:0] be, input int gap);
    waitReady();
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        avs.avs_write = 1'b0;
        repeat (gap) tick();
      end
      avs.avs_address    = addr;
      avs.avs_write      = 1'b1;
      avs.avs_writedata  = wrBuf[k];
      avs.avs_byteenable = be;
      avs.avs_burstcount = 5'(n);
      tick();
      mergeModel(addr + 8'(k), wrBuf[k], be);
    end
    avs.avs_write = 1'b0;
  endtask

  task automatic readBurst(input logic [7:0] addr, input int n, input string tag);
    waitReady();
    avs.avs_address    = addr;
    avs.avs_read       = 1'b1;
    avs.avs_burstcount = 5'(n);
    tick();
    avs.avs_read = 1'b0;
    for (int c = 1; c <= n + 2; c++) begin
      checkOutput({tag, " readdatavalid"}, 32'(avs.avs_readdatavalid), 32'(c >= 2 && c <= n + 1));
      checkOutput({tag, " waitrequest"}, 32'(avs.avs_waitrequest), 32'(c <= n + 1));
      if (c >= 2 && c <= n + 1) checkOutput({tag, " readdata"}, avs.avs_readdata, expBuf[c-2]);
      if (c < n + 2) tick();
    end
  endtask

  task automatic issueIllegal(input logic rd, input logic wr, input logic [7:0] addr,
                              input logic [4:0] bc, input logic [7:0] expCnt, input string tag);
    waitReady();
    avs.avs_read       = rd;
    avs.avs_write      = wr;
    avs.avs_address    = addr;
    avs.avs_writedata  = 32'h0BAD0BAD;
    avs.avs_byteenable = 4'hF;
    avs.avs_burstcount = bc;
    tick();
    avs.avs_read  = 1'b0;
    avs.avs_write = 1'b0;
    checkOutput({tag, " protocol_err pulse"}, 32'(protocolErr), 32'd1);
    checkOutput({tag, " err_count"}, 32'(errCount), 32'(expCnt));
    checkOutput({tag, " no readdatavalid"}, 32'(avs.avs_readdatavalid), 32'd0);
    tick();
    checkOutput({tag, " protocol_err end"}, 32'(protocolErr), 32'd0);
    checkOutput({tag, " no readdatavalid later"}, 32'(avs.avs_readdatavalid), 32'd0);
    checkOutput({tag, " still idle"}, 32'(avs.avs_waitrequest), 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    case (v.kind)
      VEC_WR: begin
        wrBuf[0] = v.data;
        writeBurst(v.addr, 1, v.be, 0);
        checkOutput({tag, " err_count"}, 32'(errCount), 32'(v.expErr));
      end
      VEC_RD: begin
        expBuf[0] = v.expData;
        readBurst(v.addr, 1, tag);
      end
      default: issueIllegal(v.rd, v.wr, v.addr, v.bc, v.expErr, tag);
    endcase
  endtask

  initial begin
    vecs[0] = '{VEC_WR,  1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 5'd1,  32'h0,        8'd0};
    vecs[1] = '{VEC_RD,  1'b1, 1'b0, 8'h10, 32'h0,        4'hF, 5'd1,  32'hDEADBEEF, 8'd0};
    vecs[2] = '{VEC_WR,  1'b0, 1'b1, 8'h05, 32'h11223344, 4'hF, 5'd1,  32'h0,        8'd0};
    vecs[3] = '{VEC_WR,  1'b0, 1'b1, 8'h05, 32'hAABBCCDD, 4'h5, 5'd1,  32'h0,        8'd0};
    vecs[4] = '{VEC_RD,  1'b1, 1'b0, 8'h05, 32'h0,        4'h0, 5'd1,  32'h11BB33DD, 8'd0};
    vecs[5] = '{VEC_ILL, 1'b1, 1'b0, 8'h10, 32'h0,        4'hF, 5'd0,  32'h0,        8'd1};
    vecs[6] = '{VEC_ILL, 1'b1, 1'b1, 8'h10, 32'h0,        4'hF, 5'd1,  32'h0,        8'd2};
    vecs[7] = '{VEC_ILL, 1'b1, 1'b0, 8'h10, 32'h0,        4'hF, 5'd17, 32'h0,        8'd3};
    vecs[8] = '{VEC_RD,  1'b1, 1'b0, 8'h10, 32'h0,        4'hF, 5'd1,  32'hDEADBEEF, 8'd3};

    avs.avs_address    = '0;
    avs.avs_read       = 1'b0;
    avs.avs_write      = 1'b0;
    avs.avs_writedata  = '0;
    avs.avs_byteenable = '0;
    avs.avs_burstcount = '0;
    resetN = 1'b0;

    // Reset and release
    repeat (3) tick();
    checkOutput("reset waitrequest", 32'(avs.avs_waitrequest), 32'd1);
    checkOutput("reset readdatavalid", 32'(avs.avs_readdatavalid), 32'd0);
    checkOutput("reset readdata", avs.avs_readdata, 32'd0);
    checkOutput("reset err_count", 32'(errCount), 32'd0);
    checkOutput("reset protocol_err", 32'(protocolErr), 32'd0);
    resetN = 1'b1;
    #1;
    checkOutput("release waitrequest before edge", 32'(avs.avs_waitrequest), 32'd1);
    tick();
    checkOutput("release waitrequest after edge", 32'(avs.avs_waitrequest), 32'd0);

    // Fill the whole RAM so every later read has a known model value
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) wrBuf[k] = $urandom;
      writeBurst(8'(b * 16), 16, 4'hF, 0);
    end

    // Vector table
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    // Burst write with gaps, then burst read
    for (int k = 0; k < 4; k++) wrBuf[k] = 32'(k + 1);
    writeBurst(8'h20, 4, 4'hF, 2);
    for (int k = 0; k < 4; k++) expBuf[k] = 32'(k + 1);
    readBurst(8'h20, 4, "burst 0x20");

    // Wrap across the top of the address space
    wrBuf[0] = 32'hAAAA000A;
    wrBuf[1] = 32'hBBBB000B;
    wrBuf[2] = 32'hCCCC000C;
    writeBurst(8'hFE, 3, 4'hF, 0);
    expBuf[0] = 32'hAAAA000A;
    expBuf[1] = 32'hBBBB000B;
    expBuf[2] = 32'hCCCC000C;
    readBurst(8'hFE, 3, "wrap read");
    expBuf[0] = 32'hCCCC000C;
    readBurst(8'h00, 1, "wrap addr0");

    // Read asserted during a write burst is dropped
    wrBuf[0] = 32'h30303030;
    wrBuf[1] = 32'h31313131;
    waitReady();
    avs.avs_address    = 8'h30;
    avs.avs_write      = 1'b1;
    avs.avs_writedata  = wrBuf[0];
    avs.avs_byteenable = 4'hF;
    avs.avs_burstcount = 5'd2;
    tick();
    mergeModel(8'h30, wrBuf[0], 4'hF);
    avs.avs_read      = 1'b1;
    avs.avs_writedata = 32'hBADBAD00;
    tick();
    checkOutput("wrburst read protocol_err", 32'(protocolErr), 32'd1);
    checkOutput("wrburst read err_count", 32'(errCount), 32'd4);
    avs.avs_read      = 1'b0;
    avs.avs_writedata = wrBuf[1];
    tick();
    mergeModel(8'h31, wrBuf[1], 4'hF);
    avs.avs_write = 1'b0;
    checkOutput("wrburst protocol_err end", 32'(protocolErr), 32'd0);
    checkOutput("wrburst back to idle", 32'(avs.avs_waitrequest), 32'd0);
    loadExpFromModel(8'h30, 3);
    readBurst(8'h30, 3, "wrburst readback");

    // Random bursts against the array model
    for (int r = 0; r < 40; r++) begin
      logic [7:0] a;
      int n;
      a = 8'($urandom);
      n = $urandom_range(1, 16);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < n; k++) wrBuf[k] = $urandom;
        writeBurst(a, n, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
      end else begin
        loadExpFromModel(a, n);
        readBurst(a, n, "random read");
      end
    end

    // err_count saturation
    for (int e = 5; e <= 255; e++) issueIllegal(1'b1, 1'b0, 8'h00, 5'd0, 8'(e), "saturate");
    issueIllegal(1'b0, 1'b1, 8'h00, 5'd0, 8'd255, "saturated");

    // Reset in the middle of a read burst
    loadExpFromModel(8'h80, 8);
    waitReady();
    avs.avs_address    = 8'h80;
    avs.avs_read       = 1'b1;
    avs.avs_burstcount = 5'd8;
    tick();
    avs.avs_read = 1'b0;
    tick();
    checkOutput("abort beat0 valid", 32'(avs.avs_readdatavalid), 32'd1);
    checkOutput("abort beat0 data", avs.avs_readdata, expBuf[0]);
    tick();
    tick();
    checkOutput("abort beat2 valid", 32'(avs.avs_readdatavalid), 32'd1);
    checkOutput("abort beat2 data", avs.avs_readdata, expBuf[2]);
    resetN = 1'b0;
    #1;
    checkOutput("abort valid drops", 32'(avs.avs_readdatavalid), 32'd0);
    checkOutput("abort waitrequest", 32'(avs.avs_waitrequest), 32'd1);
    checkOutput("abort err_count cleared", 32'(errCount), 32'd0);
    repeat (3) tick();
    resetN = 1'b1;
    loadExpFromModel(8'h81, 1);
    readBurst(8'h81, 1, "after read abort");

    // Reset in the middle of a write burst keeps the beats already written
    wrBuf[0] = 32'h40404040;
    wrBuf[1] = 32'h41414141;
    waitReady();
    avs.avs_address    = 8'h40;
    avs.avs_write      = 1'b1;
    avs.avs_writedata  = wrBuf[0];
    avs.avs_byteenable = 4'hF;
    avs.avs_burstcount = 5'd4;
    tick();
    mergeModel(8'h40, wrBuf[0], 4'hF);
    avs.avs_writedata = wrBuf[1];
    tick();
    mergeModel(8'h41, wrBuf[1], 4'hF);
    avs.avs_write = 1'b0;
    resetN = 1'b0;
    repeat (3) tick();
    resetN = 1'b1;
    loadExpFromModel(8'h40, 4);
    readBurst(8'h40, 4, "after write abort");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
